// File: rtl/wu_fetch.sv
// wu_fetch: work-unit instruction fetch sequencer.
// Walks a program region of WU instruction memory, issuing one registered
// read per line. A credit counter sized to the decode input buffer paces the
// reads, because wu_memory has a fixed 2-cycle latency and cannot stall.
// ADDR_W is the width of the manager WU address range.
module wu_fetch #(
    parameter int CREDITS = 4,
    parameter int LEN_W   = 10,
    parameter int ADDR_W  = 10
) (
    input  logic              clk,
    input  logic              reset_poweron,
    input  logic              cfg__wuf__start,
    input  logic [ADDR_W-1:0] cfg__wuf__start_addr,
    input  logic [LEN_W-1:0]  cfg__wuf__length,
    input  logic              cfg__wuf__abort,
    input  logic              wud__wuf__stall,
    input  logic              wud__wuf__release,
    output logic [ADDR_W-1:0] wuf__wum__addr,
    output logic              wuf__wum__read,
    output logic              wuf__cfg__busy,
    output logic              wuf__cfg__done,
    output logic              wuf__cfg__credit_err
);

    // state | meaning
    // IDLE  | waiting for a start pulse
    // FETCH | issuing reads while lines remain, credits allow and decode is not stalled
    // DRAIN | two cycles covering the wu_memory latency; done in the second

    localparam int CRED_W = $clog2(CREDITS + 1);
    localparam logic [CRED_W-1:0] CRED_MAX = CRED_W'(CREDITS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [ADDR_W-1:0] ptr;
    logic [LEN_W-1:0]  remaining;
    logic [CRED_W-1:0] credits;
    logic              drain_cnt;

    logic rel_ok;
    logic rel_drop;
    logic credit_avail;
    logic issue;
    logic start_load;

    // A release arriving this cycle can fund a read on the same edge, so a
    // single release against an empty counter yields a read in the next cycle.
    assign rel_ok       = wud__wuf__release && (credits != CRED_MAX);
    assign rel_drop     = wud__wuf__release && (credits == CRED_MAX);
    assign credit_avail = (credits != '0) || rel_ok;
    assign issue        = (state == FETCH) && (remaining != '0) && credit_avail
                          && !wud__wuf__stall && !cfg__wuf__abort;
    assign start_load   = (state == IDLE) && cfg__wuf__start && (cfg__wuf__length != '0);

    // State register.
    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic. FETCH leaves one cycle after the last read so that the
    // two DRAIN cycles line up with the last line returning from memory.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (cfg__wuf__start) begin
                    state_nxt = (cfg__wuf__length != '0) ? FETCH : DRAIN;
                end
            end
            FETCH: begin
                if (cfg__wuf__abort || (remaining == '0)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Status outputs decoded from state.
    always_comb begin
        wuf__cfg__busy = (state != IDLE);
        wuf__cfg__done = (state == DRAIN) && drain_cnt;
    end

    // Address pointer, line count, drain timer and registered read port.
    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            ptr            <= '0;
            remaining      <= '0;
            drain_cnt      <= 1'b0;
            wuf__wum__read <= 1'b0;
            wuf__wum__addr <= '0;
        end else begin
            wuf__wum__read <= issue;
            drain_cnt      <= (state == DRAIN) ? !drain_cnt : 1'b0;
            if (start_load) begin
                ptr       <= cfg__wuf__start_addr;
                remaining <= cfg__wuf__length;
            end else if (issue) begin
                ptr       <= ptr + ADDR_W'(1);
                remaining <= remaining - LEN_W'(1);
            end
            if (issue) begin
                wuf__wum__addr <= ptr;
            end
        end
    end

    // Credit counter; never reloaded on start since decode may still hold
    // entries from the previous program. An overflowing release is dropped.
    always_ff @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            credits              <= CRED_MAX;
            wuf__cfg__credit_err <= 1'b0;
        end else begin
            case ({rel_ok, issue})
                2'b10:   credits <= credits + CRED_W'(1);
                2'b01:   credits <= credits - CRED_W'(1);
                default: credits <= credits;
            endcase
            if (rel_drop) begin
                wuf__cfg__credit_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_wu_fetch.sv
// Testbench for wu_fetch: directed steps with a scoreboard of expected
// read (cycle, address) pairs and expected done cycles.
module tb_wu_fetch;

    localparam int AW = 10;
    localparam int LW = 10;

    typedef struct {
        int          cyc;
        logic [AW-1:0] addr;
    } rd_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_poweron;
    logic          start;
    logic          start2;
    logic [AW-1:0] start_addr;
    logic [LW-1:0] length;
    logic          abort;
    logic          stall;
    logic          man_rel;
    logic          rel2;
    logic          auto_rel;
    logic          rel0;
    logic          rd_d1;
    logic          rd_d2;

    logic [1:0]         m_read;
    logic [1:0]         m_busy;
    logic [1:0]         m_done;
    logic [1:0]         m_err;
    logic [1:0][AW-1:0] m_addr;

    rd_t exp_rd0[$];
    rd_t exp_rd1[$];
    int  exp_dn0[$];
    int  exp_dn1[$];

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;

    // Decode model for the main instance: frees one entry per line, in the
    // cycle the line becomes valid (two cycles after its read).
    assign rel0 = (auto_rel & rd_d2) | man_rel;

    always @(posedge clk or posedge reset_poweron) begin
        if (reset_poweron) begin
            rd_d1 <= 1'b0;
            rd_d2 <= 1'b0;
        end else begin
            rd_d1 <= m_read[0];
            rd_d2 <= rd_d1;
        end
    end

    wu_fetch #(.CREDITS(4), .LEN_W(LW), .ADDR_W(AW)) dut (
        .clk                  (clk),
        .reset_poweron        (reset_poweron),
        .cfg__wuf__start      (start),
        .cfg__wuf__start_addr (start_addr),
        .cfg__wuf__length     (length),
        .cfg__wuf__abort      (abort),
        .wud__wuf__stall      (stall),
        .wud__wuf__release    (rel0),
        .wuf__wum__addr       (m_addr[0]),
        .wuf__wum__read       (m_read[0]),
        .wuf__cfg__busy       (m_busy[0]),
        .wuf__cfg__done       (m_done[0]),
        .wuf__cfg__credit_err (m_err[0])
    );

    wu_fetch #(.CREDITS(2), .LEN_W(LW), .ADDR_W(AW)) dut2 (
        .clk                  (clk),
        .reset_poweron        (reset_poweron),
        .cfg__wuf__start      (start2),
        .cfg__wuf__start_addr (start_addr),
        .cfg__wuf__length     (length),
        .cfg__wuf__abort      (abort),
        .wud__wuf__stall      (stall),
        .wud__wuf__release    (rel2),
        .wuf__wum__addr       (m_addr[1]),
        .wuf__wum__read       (m_read[1]),
        .wuf__cfg__busy       (m_busy[1]),
        .wuf__cfg__done       (m_done[1]),
        .wuf__cfg__credit_err (m_err[1])
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard pop/compare for every read strobe and done pulse.
    task automatic check_outputs();
        rd_t e;
        int  sz;
        int  d;
        for (int k = 0; k < 2; k++) begin
            if (m_read[k] === 1'b1) begin
                sz = (k == 0) ? exp_rd0.size() : exp_rd1.size();
                chk($sformatf("read_expected%0d@%0d", k, cyc), 32'(sz != 0), 32'd1);
                if (sz != 0) begin
                    if (k == 0) e = exp_rd0.pop_front();
                    else        e = exp_rd1.pop_front();
                    chk($sformatf("read_cycle%0d", k), 32'(cyc), 32'(e.cyc));
                    chk($sformatf("read_addr%0d@%0d", k, cyc), 32'(m_addr[k]), 32'(e.addr));
                end
            end
            if (m_done[k] === 1'b1) begin
                sz = (k == 0) ? exp_dn0.size() : exp_dn1.size();
                chk($sformatf("done_expected%0d@%0d", k, cyc), 32'(sz != 0), 32'd1);
                if (sz != 0) begin
                    if (k == 0) d = exp_dn0.pop_front();
                    else        d = exp_dn1.pop_front();
                    chk($sformatf("done_cycle%0d", k), 32'(cyc), 32'(d));
                end
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        cyc++;
        #1;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) tick();
    endtask

    task automatic chk_empty(input string tag);
        chk({tag, "_reads0_left"}, 32'(exp_rd0.size()), 32'd0);
        chk({tag, "_dones0_left"}, 32'(exp_dn0.size()), 32'd0);
        chk({tag, "_reads1_left"}, 32'(exp_rd1.size()), 32'd0);
        chk({tag, "_dones1_left"}, 32'(exp_dn1.size()), 32'd0);
    endtask

    int t;
    int c;

    initial begin
        reset_poweron = 1'b1;
        start = 1'b0; start2 = 1'b0; start_addr = '0; length = '0;
        abort = 1'b0; stall = 1'b0; man_rel = 1'b0; rel2 = 1'b0; auto_rel = 1'b1;
        #1;
        repeat (3) tick();
        reset_poweron = 1'b0;

        // Reset state
        chk("rst_read",    32'(m_read[0]), 32'd0);
        chk("rst_addr",    32'(m_addr[0]), 32'd0);
        chk("rst_busy",    32'(m_busy[0]), 32'd0);
        chk("rst_done",    32'(m_done[0]), 32'd0);
        chk("rst_err",     32'(m_err[0]),  32'd0);
        chk("rst_credits", 32'(dut.credits),  32'd4);
        chk("rst_credits2", 32'(dut2.credits), 32'd2);
        repeat (2) tick();

        // Credit exhaustion on the 2-credit instance, no releases
        t = cyc;
        start2 = 1'b1; start_addr = 10'h100; length = 10'd4;
        exp_rd1.push_back('{t + 2, 10'h100});
        exp_rd1.push_back('{t + 3, 10'h101});
        tick();
        start2 = 1'b0;
        wait_until(t + 8);
        chk("cx_two_reads", 32'(exp_rd1.size()), 32'd0);
        chk("cx_credits0",  32'(dut2.credits), 32'd0);
        chk("cx_busy",      32'(m_busy[1]), 32'd1);
        c = cyc;
        rel2 = 1'b1;
        exp_rd1.push_back('{c + 1, 10'h102});
        tick();
        rel2 = 1'b0;
        wait_until(c + 4);
        chk("cx_still_busy", 32'(m_busy[1]), 32'd1);
        c = cyc;
        rel2 = 1'b1;
        exp_rd1.push_back('{c + 1, 10'h103});
        exp_dn1.push_back(c + 3);
        tick();
        rel2 = 1'b0;
        wait_until(c + 6);
        chk_empty("cx");
        chk("cx_idle", 32'(m_busy[1]), 32'd0);

        // Basic fetch
        t = cyc;
        start = 1'b1; start_addr = 10'h010; length = 10'd5;
        for (int i = 0; i < 5; i++) exp_rd0.push_back('{t + 2 + i, AW'(10'h010 + i)});
        exp_dn0.push_back(t + 8);
        tick();
        start = 1'b0;
        chk("basic_busy_rise", 32'(m_busy[0]), 32'd1);
        wait_until(t + 8);
        chk("basic_busy_t8", 32'(m_busy[0]), 32'd1);
        wait_until(t + 9);
        chk("basic_busy_fall", 32'(m_busy[0]), 32'd0);
        wait_until(t + 11);
        chk_empty("basic");
        chk("basic_credits", 32'(dut.credits), 32'd4);

        // Address wrap
        t = cyc;
        start = 1'b1; start_addr = 10'h3FF; length = 10'd3;
        exp_rd0.push_back('{t + 2, 10'h3FF});
        exp_rd0.push_back('{t + 3, 10'h000});
        exp_rd0.push_back('{t + 4, 10'h001});
        exp_dn0.push_back(t + 6);
        tick();
        start = 1'b0;
        wait_until(t + 10);
        chk_empty("wrap");
        chk("wrap_err", 32'(m_err[0]), 32'd0);

        // Stall for cycles t+3..t+5
        t = cyc;
        start = 1'b1; start_addr = 10'h020; length = 10'd6;
        exp_rd0.push_back('{t + 2, 10'h020});
        exp_rd0.push_back('{t + 3, 10'h021});
        for (int i = 0; i < 4; i++) exp_rd0.push_back('{t + 7 + i, AW'(10'h022 + i)});
        exp_dn0.push_back(t + 12);
        tick();
        start = 1'b0;
        wait_until(t + 3);
        stall = 1'b1;
        wait_until(t + 6);
        stall = 1'b0;
        wait_until(t + 15);
        chk_empty("stall");
        chk("stall_credits", 32'(dut.credits), 32'd4);

        // Abort on the 2nd read, then a start during DRAIN that must be ignored
        t = cyc;
        start = 1'b1; start_addr = 10'h200; length = 10'd10;
        exp_rd0.push_back('{t + 2, 10'h200});
        exp_rd0.push_back('{t + 3, 10'h201});
        exp_dn0.push_back(t + 5);
        tick();
        start = 1'b0;
        wait_until(t + 3);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        start = 1'b1; start_addr = 10'h300; length = 10'd3;
        tick();
        start = 1'b0;
        chk("abort_busy_drain", 32'(m_busy[0]), 32'd1);
        wait_until(t + 6);
        chk("abort_busy_fall", 32'(m_busy[0]), 32'd0);
        wait_until(t + 10);
        chk("ignored_start_idle", 32'(m_busy[0]), 32'd0);
        chk_empty("abort");

        // Zero-length program
        t = cyc;
        start = 1'b1; start_addr = 10'h055; length = 10'd0;
        exp_dn0.push_back(t + 2);
        tick();
        start = 1'b0;
        chk("len0_busy", 32'(m_busy[0]), 32'd1);
        wait_until(t + 3);
        chk("len0_busy_fall", 32'(m_busy[0]), 32'd0);
        wait_until(t + 5);
        chk_empty("len0");

        // Release while credits are full
        chk("err_before", 32'(m_err[0]), 32'd0);
        man_rel = 1'b1;
        tick();
        man_rel = 1'b0;
        chk("err_set", 32'(m_err[0]), 32'd1);
        chk("err_credits", 32'(dut.credits), 32'd4);
        tick();

        // Asynchronous reset mid-FETCH
        t = cyc;
        start = 1'b1; start_addr = 10'h050; length = 10'd10;
        exp_rd0.push_back('{t + 2, 10'h050});
        exp_rd0.push_back('{t + 3, 10'h051});
        tick();
        start = 1'b0;
        wait_until(t + 4);
        chk("pre_rst_read", 32'(m_read[0]), 32'd1);
        chk("pre_rst_addr", 32'(m_addr[0]), 32'h052);
        #2;
        reset_poweron = 1'b1;
        #1;
        chk("arst_read",    32'(m_read[0]), 32'd0);
        chk("arst_addr",    32'(m_addr[0]), 32'd0);
        chk("arst_busy",    32'(m_busy[0]), 32'd0);
        chk("arst_done",    32'(m_done[0]), 32'd0);
        chk("arst_err",     32'(m_err[0]),  32'd0);
        chk("arst_credits", 32'(dut.credits),  32'd4);
        chk("arst_credits2", 32'(dut2.credits), 32'd2);
        tick();
        reset_poweron = 1'b0;
        repeat (4) tick();
        chk("post_rst_busy", 32'(m_busy[0]), 32'd0);
        chk_empty("arst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
